multu_seq: RTL and testbench
============================

# multu_seq

Sequential 32×32 shift-add multiplier for the EX stage, executing MULT (signed) and MULTU (unsigned) over a fixed 33-cycle latency. It is the producer side of the Hi/Lo interface: it drives the 64-bit product on `MulAns` and raises `MULSignal` to the done code for exactly one cycle, which tells the Hi/Lo register to commit `MulAns` into Hi/Lo. The pipeline controller watches `busy` to stall any MFHI/MFLO that follows.

## Interface
- `WIDTH`, default 32: operand width. The product is 2·WIDTH bits.
- `clk` input, 1 bit: the single clock. All state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `Signal` input, 6 bits: funct field. `6'b011000` = MULT and `6'b011001` = MULTU start an operation. Every other value is ignored.
- `dataA` input, WIDTH bits: multiplicand (rs).
- `dataB` input, WIDTH bits: multiplier (rt).
- `MulAns` output, 2·WIDTH bits: product register. It holds the last completed product.
- `MULSignal` output, 6 bits: `6'b111111` during the done cycle, otherwise `6'b000000`.
- `busy` output, 1 bit: high in the RUN and DONE states.

## Operation
- State machine with states IDLE, RUN and DONE. Reset forces IDLE, `MulAns`=0, `MULSignal`=0, `busy`=0, counter=0 and accumulator=0.
- **IDLE:** a start (`Signal` equal to MULT or MULTU) is captured on the edge.
  - Sign flag = (`dataA[31]` ^ `dataB[31]`) for MULT, and 0 for MULTU.
  - For MULT, operands are replaced by their magnitudes. |−2³¹| = 0x80000000 is a valid unsigned magnitude.
  - Accumulator = {33'b0, magnitude B}; multiplicand register = magnitude A; counter=0. Next state is RUN.
- **RUN:** one iteration per edge.
  - If accumulator[0] is set, add the multiplicand to the upper part. The upper part is 33 bits so the carry is kept.
  - The accumulator then shifts right by 1.
  - The counter increments. After the iteration with counter=31, the next state is DONE and `MulAns` is loaded with the 64-bit accumulator result. If the sign flag is set, the two's complement of that result is loaded instead.
- **DONE:** `MULSignal`=`6'b111111` and `MulAns` is valid. Next state is IDLE unconditionally.
- **Start while busy:** a start seen in RUN or DONE is ignored and dropped, not queued. The issuing pipeline stalls on `busy`.
- **`MulAns` stability:** `MulAns` changes only on the edge that enters DONE, or on reset. It stays stable throughout RUN, so Hi/Lo reads of the previous result stay coherent.
- **Reset mid-operation:** the operation is aborted and all registers clear on that edge. No done pulse is produced.

## Timing
- Start sampled at edge T. RUN covers the cycles after edges T … T+31. DONE occupies the cycle after edge T+32.
- The result is visible and `MULSignal`=`111111` in that single cycle. The state is IDLE after edge T+33.
- `busy` rises after edge T and falls after edge T+33. The earliest next start is sampled at edge T+33 (during DONE, which is ignored) or later. A start must therefore be presented in the IDLE cycle following DONE.
- Total: 33 cycles from start to done pulse, and a 34-cycle minimum issue interval.
- The done pulse is exactly one cycle wide and is never asserted in IDLE or RUN.

## Structure
- Shared package `mul_pkg` holds:
  - the funct constants `FUNCT_MULT` and `FUNCT_MULTU`;
  - the done code `MUL_DONE` = `6'b111111`;
  - the state encoding (IDLE, RUN, DONE).
- This is a single module with no sub-module. The datapath (33-bit adder, 65-bit shift accumulator, 5-bit counter, final negate) is small enough to remain inline.

## Test plan
- **Unsigned maximum:** MULTU with 0xFFFFFFFF × 0xFFFFFFFF at edge T → `MulAns`=0xFFFFFFFE_00000001 and `MULSignal`=`111111` in the cycle after edge T+32 only, then 0.
- **Signed mixed signs:** MULT with −3 (0xFFFFFFFD) × 7 → `MulAns`=0xFFFFFFFF_FFFFFFEB. MULTU on the same operands → 0x00000006_FFFFFFEB.
- **Signed corner:** MULT with 0x80000000 × 0x80000000 → 0x40000000_00000000. MULT with 0x80000000 × 1 → 0xFFFFFFFF_80000000.
- **Ignored start:** a second MULTU of 5 × 5 is issued at edge T+10 during a 2×3 operation → exactly one done pulse, `MulAns`=6, and `busy` timing is unchanged. A later start in IDLE yields 25.
- **Reset mid-operation:** `reset` asserted at edge T+12 → next cycle has `MulAns`=0, `MULSignal`=0, `busy`=0, and no pulse appears for 40 cycles. A fresh MULT of −1 × −1 then yields 1.
- **Stability and non-start functs:** `MulAns` is held constant through all of RUN, checked cycle-by-cycle. `Signal`=`6'b100000` (ADD) while in IDLE produces no `busy`.

Source files
------------

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_pkg
//  Brief    : Shared funct codes, done code and FSM encoding for multu_seq.
//  Revision : 1.0
// ============================================================================
package mul_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] MUL_DONE    = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/multu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : multu_seq_if
//  Brief    : Issue/result bundle between the EX stage and the multiplier.
//  Revision : 1.0
// ============================================================================
interface multu_seq_if #(
    parameter int WIDTH = 32
);
    logic [5:0]         Signal;
    logic [WIDTH-1:0]   dataA;
    logic [WIDTH-1:0]   dataB;
    logic [2*WIDTH-1:0] MulAns;
    logic [5:0]         MULSignal;
    logic               busy;

    modport master (
        output Signal, dataA, dataB,
        input  MulAns, MULSignal, busy
    );

    modport slave (
        input  Signal, dataA, dataB,
        output MulAns, MULSignal, busy
    );
endinterface
`default_nettype wire

// File: rtl/multu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : multu_seq
//  Brief    : 33-cycle shift-add multiplier for MULT/MULTU, Hi/Lo producer.
//  Revision : 1.0
// ============================================================================
module multu_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire          clk,
    input  wire          reset,
    multu_seq_if.slave   mif
);

    localparam int CW = $clog2(WIDTH);

    mul_state_t         r_state, w_state_nxt;
    logic [2*WIDTH:0]   r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_mcand, w_mcand_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_sign, w_sign_nxt;
    logic [2*WIDTH-1:0] r_ans, w_ans_nxt;

    logic               w_start;
    logic               w_is_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_upper;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_start     = (mif.Signal == FUNCT_MULT) || (mif.Signal == FUNCT_MULTU);
        w_is_signed = (mif.Signal == FUNCT_MULT);
        w_mag_a     = (w_is_signed && mif.dataA[WIDTH-1]) ? -mif.dataA : mif.dataA;
        w_mag_b     = (w_is_signed && mif.dataB[WIDTH-1]) ? -mif.dataB : mif.dataB;

        // Upper part is WIDTH+1 bits wide so the add carry survives the shift.
        w_addend    = r_acc[0] ? {1'b0, r_mcand} : '0;
        w_upper     = r_acc[2*WIDTH:WIDTH] + w_addend;
        w_prod      = {w_upper, r_acc[WIDTH-1:1]};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_mcand_nxt = r_mcand;
        w_cnt_nxt   = r_cnt;
        w_sign_nxt  = r_sign;
        w_ans_nxt   = r_ans;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_acc_nxt   = {{(WIDTH+1){1'b0}}, w_mag_b};
                    w_mcand_nxt = w_mag_a;
                    w_cnt_nxt   = '0;
                    w_sign_nxt  = w_is_signed & (mif.dataA[WIDTH-1] ^ mif.dataB[WIDTH-1]);
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_acc_nxt = {1'b0, w_prod};
                w_cnt_nxt = r_cnt + CW'(1);
                // Product register only moves here, so Hi/Lo reads stay coherent during RUN.
                if (r_cnt == CW'(WIDTH-1)) begin
                    w_ans_nxt   = r_sign ? -w_prod : w_prod;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_ans   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_mcand <= w_mcand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sign  <= w_sign_nxt;
            r_ans   <= w_ans_nxt;
        end
    end

    assign mif.MulAns    = r_ans;
    assign mif.MULSignal = (r_state == ST_DONE) ? MUL_DONE : 6'b000000;
    assign mif.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multu_seq
//  Brief    : Directed vector bench for multu_seq, with multi-cycle sequences.
//  Revision : 1.0
// ============================================================================
module tb_multu_seq;
    import mul_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multu_seq_if #(.WIDTH(32)) mif();
    multu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    typedef struct {
        string       name;
        logic [5:0]  sig;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[10];
    int          passed = 0;
    int          total  = 0;
    logic [63:0] last_exp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
        mif.Signal = s;
        mif.dataA  = a;
        mif.dataB  = b;
    endtask

    // Issues one op and walks it cycle by cycle; inj_k > 0 presents a second
    // request before edge T+inj_k, which must be dropped.
    task automatic run_op(input string name, input logic [5:0] sig, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int inj_k,
                          input logic [5:0] inj_sig, input logic [31:0] inj_a, input logic [31:0] inj_b);
        int pulses = 0;
        @(negedge clk); drive(sig, a, b);
        @(posedge clk); #1;
        chk({name, " start"}, {mif.busy, mif.MULSignal, mif.MulAns}, {1'b1, 6'b0, last_exp});
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == inj_k) drive(inj_sig, inj_a, inj_b);
            else drive(6'b0, 32'h0, 32'h0);
            @(posedge clk); #1;
            if (mif.MULSignal == MUL_DONE) pulses++;
            if (k < 32)
                chk({name, " run"}, {mif.busy, mif.MULSignal, mif.MulAns}, {1'b1, 6'b0, last_exp});
            else if (k == 32)
                chk({name, " done"}, {mif.busy, mif.MULSignal, mif.MulAns}, {1'b1, MUL_DONE, exp});
            else
                chk({name, " idle"}, {mif.busy, mif.MULSignal, mif.MulAns}, {1'b0, 6'b0, exp});
        end
        @(negedge clk); drive(6'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk({name, " no requeue"}, {mif.busy, mif.MULSignal}, {1'b0, 6'b0});
        chk({name, " pulses"}, pulses, 1);
        last_exp = exp;
    endtask

    initial begin
        int pulses;
        int busy_cnt;

        vecs[0] = '{"umax",    FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[1] = '{"smix",    FUNCT_MULT,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB};
        vecs[2] = '{"umix",    FUNCT_MULTU, 32'hFFFFFFFD, 32'h00000007, 64'h00000006_FFFFFFEB};
        vecs[3] = '{"smin2",   FUNCT_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[4] = '{"sminx1",  FUNCT_MULT,  32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000};
        vecs[5] = '{"smax2",   FUNCT_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
        vecs[6] = '{"sposneg", FUNCT_MULT,  32'h00000005, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFEC};
        vecs[7] = '{"szero",   FUNCT_MULT,  32'h00000000, 32'hFFFFFFFF, 64'h00000000_00000000};
        vecs[8] = '{"udec",    FUNCT_MULTU, 32'h00003039, 32'h00001A85, 64'h00000000_04FED79D};
        vecs[9] = '{"snegpos", FUNCT_MULT,  32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE};

        reset = 1'b1;
        drive(6'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", {mif.busy, mif.MULSignal, mif.MulAns}, {1'b0, 6'b0, 64'h0});
        @(negedge clk); reset = 1'b0;
        last_exp = 64'h0;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].sig, vecs[i].a, vecs[i].b, vecs[i].exp, 0, 6'b0, 32'h0, 32'h0);

        run_op("ignored start", FUNCT_MULTU, 32'd2, 32'd3, 64'd6, 10, FUNCT_MULTU, 32'd5, 32'd5);
        run_op("later start", FUNCT_MULTU, 32'd5, 32'd5, 64'd25, 0, 6'b0, 32'h0, 32'h0);
        run_op("start in done", FUNCT_MULTU, 32'd4, 32'd4, 64'd16, 33, FUNCT_MULTU, 32'd9, 32'd9);

        // Abort at edge T+12.
        @(negedge clk); drive(FUNCT_MULTU, 32'h00001234, 32'h00000010);
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk); drive(6'b0, 32'h0, 32'h0);
            @(posedge clk);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("reset mid-op", {mif.busy, mif.MULSignal, mif.MulAns}, {1'b0, 6'b0, 64'h0});
        @(negedge clk); reset = 1'b0;
        last_exp = 64'h0;
        pulses = 0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (mif.MULSignal != 6'b0) pulses++;
            if (mif.busy) busy_cnt++;
        end
        chk("abort no pulse", pulses, 0);
        chk("abort no busy", busy_cnt, 0);
        run_op("neg1 sq", FUNCT_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 0, 6'b0, 32'h0, 32'h0);

        // ADD funct in IDLE must not start anything.
        @(negedge clk); drive(6'b100000, 32'd3, 32'd4);
        @(posedge clk); #1;
        chk("add no busy", mif.busy, 1'b0);
        @(negedge clk); drive(6'b0, 32'h0, 32'h0);
        pulses = 0;
        busy_cnt = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk); #1;
            if (mif.MULSignal != 6'b0) pulses++;
            if (mif.busy) busy_cnt++;
        end
        chk("add no pulse", {pulses, busy_cnt}, 64'h0);
        chk("add ans held", mif.MulAns, last_exp);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
